// File: rtl/multdiv_pkg.sv
// multdiv shared types and constants.
// Iteration count, widths and FSM encoding.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = 32;
  localparam logic [MD_WIDTH-1:0] MD_INT_MIN = 32'h8000_0000;

  typedef logic [4:0] cnt_t;

  localparam cnt_t MD_LAST = cnt_t'(MD_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/multdiv_if.sv
// multdiv processor-side bundle.
// Operands and start pulses in, result and strobe out.
interface multdiv_if;
  import multdiv_pkg::*;

  logic [MD_WIDTH-1:0] data_operandA;
  logic [MD_WIDTH-1:0] data_operandB;
  logic                ctrl_MULT;
  logic                ctrl_DIV;
  logic [MD_WIDTH-1:0] data_result;
  logic                data_exception;
  logic                data_resultRDY;

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    output ctrl_DIV,
    input  data_result,
    input  data_exception,
    input  data_resultRDY
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    input  ctrl_DIV,
    output data_result,
    output data_exception,
    output data_resultRDY
  );

endinterface

// File: rtl/multdiv_div_core.sv
// Restoring divider on unsigned magnitudes.
// One quotient bit per step; quot_next is the post-step quotient.
module div_core
  import multdiv_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                step,
  input  logic [MD_WIDTH-1:0] dividend,
  input  logic [MD_WIDTH-1:0] divisor,
  output logic [MD_WIDTH-1:0] quot_next
);

  logic [MD_WIDTH-1:0] rem;
  logic [MD_WIDTH-1:0] quo;
  logic [MD_WIDTH-1:0] dvs;
  logic [MD_WIDTH:0]   rem_shift;
  logic [MD_WIDTH-1:0] rem_next;
  logic                fits;

  // Shift in the next dividend bit, subtract if it fits, else restore
  always_comb begin
    rem_shift = {rem, quo[MD_WIDTH-1]};
    fits      = rem_shift >= {1'b0, dvs};
    rem_next  = rem_shift[MD_WIDTH-1:0];
    quot_next = {quo[MD_WIDTH-2:0], 1'b0};
    if (fits) begin
      rem_next     = MD_WIDTH'(rem_shift - {1'b0, dvs});
      quot_next[0] = 1'b1;
    end
  end

  // Load magnitudes on start, advance one bit per step
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      rem <= rem_next;
      quo <= quot_next;
    end
  end

endmodule

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply/divide, 32 cycles per op.
// MULTDIV_DIV_EN builds the divider; otherwise DIV traps.
module multdiv
  import multdiv_pkg::*;
(
  input logic      clock,
  input logic      reset,
  multdiv_if.slave bus
);

  state_t                state;
  cnt_t                  count;
  logic [MD_WIDTH-1:0]   mcand;
  logic [2*MD_WIDTH:0]   prod;
  logic [2*MD_WIDTH:0]   prod_next;
  logic [MD_WIDTH:0]     booth_sum;
  logic                  start;
  logic                  last;
  logic [MD_WIDTH-1:0]   div_res;
  logic                  div_exc;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign last  = (count == MD_LAST);

  // Booth step: 33-bit add keeps INT_MIN multiplicands exact
  always_comb begin
    booth_sum = {prod[2*MD_WIDTH], prod[2*MD_WIDTH:MD_WIDTH+1]};
    case (prod[1:0])
      2'b01:   booth_sum = booth_sum + {mcand[MD_WIDTH-1], mcand};
      2'b10:   booth_sum = booth_sum - {mcand[MD_WIDTH-1], mcand};
      default: booth_sum = booth_sum;
    endcase
    prod_next = {booth_sum, prod[MD_WIDTH:1]};
  end

`ifdef MULTDIV_DIV_EN
  logic                div_neg;
  logic                div_zero;
  logic                div_ovf;
  logic [MD_WIDTH-1:0] mag_a;
  logic [MD_WIDTH-1:0] mag_b;
  logic [MD_WIDTH-1:0] quot_next;

  assign mag_a = bus.data_operandA[MD_WIDTH-1] ?
                 -bus.data_operandA : bus.data_operandA;
  assign mag_b = bus.data_operandB[MD_WIDTH-1] ?
                 -bus.data_operandB : bus.data_operandB;

  // Capture quotient sign and special cases at the start edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_neg  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else if (start) begin
      div_neg  <= bus.data_operandA[MD_WIDTH-1] ^
                  bus.data_operandB[MD_WIDTH-1];
      div_zero <= (bus.data_operandB == '0);
      div_ovf  <= (bus.data_operandA == MD_INT_MIN) &&
                  (bus.data_operandB == '1);
    end
  end

  div_core u_div (
    .clock     (clock),
    .reset     (reset),
    .load      (start),
    .step      (state == DIV),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quot_next (quot_next)
  );

  // Signed fix-up of the final quotient, special cases override
  always_comb begin
    div_res = div_neg ? -quot_next : quot_next;
    div_exc = 1'b0;
    if (div_zero) begin
      div_res = '0;
      div_exc = 1'b1;
    end else if (div_ovf) begin
      div_res = MD_INT_MIN;
      div_exc = 1'b1;
    end
  end
`else
  assign div_res = '0;
  assign div_exc = 1'b1;
`endif

  // Control FSM, multiplier datapath and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      count              <= '0;
      mcand              <= '0;
      prod               <= '0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;
      if (start) begin
        state <= bus.ctrl_MULT ? MULT : DIV;
        count <= '0;
        mcand <= bus.data_operandA;
        prod  <= {{MD_WIDTH{1'b0}}, bus.data_operandB, 1'b0};
      end else begin
        unique case (state)
          MULT: begin
            prod  <= prod_next;
            count <= count + 5'd1;
            if (last) begin
              state              <= DONE;
              bus.data_result    <= prod_next[MD_WIDTH:1];
              bus.data_exception <=
                prod_next[2*MD_WIDTH:MD_WIDTH+1] !=
                {MD_WIDTH{prod_next[MD_WIDTH]}};
              bus.data_resultRDY <= 1'b1;
            end
          end
          DIV: begin
            count <= count + 5'd1;
            if (last) begin
              state              <= DONE;
              bus.data_result    <= div_res;
              bus.data_exception <= div_exc;
              bus.data_resultRDY <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv.
// Directed cases from the plan plus randomized back-to-back ops.
module tb_multdiv;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multdiv_if bus ();

  multdiv dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: plain signed arithmetic on 64-bit integers
  function automatic void ref_op(input bit is_mult,
                                 input logic [31:0] a, b,
                                 output logic [31:0] r,
                                 output logic e);
    longint p;
    int     sa, sb;
    sa = a;
    sb = b;
    if (is_mult) begin
      p = longint'(sa) * longint'(sb);
      r = p[31:0];
      e = (p > 64'sh7FFF_FFFF) || (p < -64'sh8000_0000);
    end else begin
`ifdef MULTDIV_DIV_EN
      if (sb == 0) begin
        r = 32'h0;
        e = 1'b1;
      end else if (a == 32'h8000_0000 && sb == -1) begin
        r = 32'h8000_0000;
        e = 1'b1;
      end else begin
        r = sa / sb;
        e = 1'b0;
      end
`else
      r = 32'h0;
      e = 1'b1;
`endif
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      4:       return -$urandom_range(1, 20);
      default: return $urandom();
    endcase
  endfunction

  // Drive a start for one edge, then scramble the operands
  task automatic start_op(input bit m, input bit d,
                          input logic [31:0] a, b);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom();
    bus.data_operandB = $urandom();
  endtask

  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    int seen;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.data_result, bus.data_exception, bus.data_resultRDY} !== 34'h0) begin
      errors++;
      $display("FAIL reset_init: got %h/%b/%b want 0/0/0",
               bus.data_result, bus.data_exception, bus.data_resultRDY);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    start_op(1'b1, 1'b0, 32'd5, 32'd6);
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus.data_result, bus.data_exception, bus.data_resultRDY} !== 34'h0) begin
      errors++;
      $display("FAIL reset_midop: got %h/%b/%b want 0/0/0",
               bus.data_result, bus.data_exception, bus.data_resultRDY);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 36; i++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) seen++;
    end
    checks++;
    if (seen != 0 || bus.data_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_no_rdy: rdy count %0d result %h want 0 and 0",
               seen, bus.data_result);
    end
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    wait_rdy(lat);
    checks++;
    if (lat != 32 || bus.data_result !== 32'd12) begin
      errors++;
      $display("FAIL reset_then_mult: latency %0d result %h want 32 and c",
               lat, bus.data_result);
    end
  endtask

  task automatic test_mult_basic();
    int lat;
    start_op(1'b1, 1'b0, 32'd7, -32'd3);
    wait_rdy(lat);
    checks++;
    if (lat != 32) begin
      errors++;
      $display("FAIL mult_latency: got %0d want 32", lat);
    end
    checks++;
    if (bus.data_result !== 32'hFFFF_FFEB || bus.data_exception !== 1'b0) begin
      errors++;
      $display("FAIL mult_7x-3: got %h/%b want ffffffeb/0",
               bus.data_result, bus.data_exception);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL rdy_one_cycle: got %b want 0", bus.data_resultRDY);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.data_result !== 32'hFFFF_FFEB || bus.data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL mult_hold: got %h/%b want ffffffeb/0",
               bus.data_result, bus.data_resultRDY);
    end
  endtask

  task automatic test_mult_overflow();
    int lat;
    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_rdy(lat);
    checks++;
    if (lat != 32 || bus.data_result !== 32'h0 || bus.data_exception !== 1'b1) begin
      errors++;
      $display("FAIL mult_2p32: lat %0d got %h/%b want 32 0/1",
               lat, bus.data_result, bus.data_exception);
    end
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_rdy(lat);
    checks++;
    if (lat != 32 || bus.data_result !== 32'h8000_0000 ||
        bus.data_exception !== 1'b1) begin
      errors++;
      $display("FAIL mult_min_x-1: lat %0d got %h/%b want 32 80000000/1",
               lat, bus.data_result, bus.data_exception);
    end
  endtask

  task automatic test_div();
    int          lat;
    logic [31:0] er;
    logic        ee;
    logic [31:0] av [4] = '{-32'd7, 32'd5, 32'h8000_0000, 32'd100};
    logic [31:0] bv [4] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7};
    for (int k = 0; k < 4; k++) begin
      ref_op(1'b0, av[k], bv[k], er, ee);
      start_op(1'b0, 1'b1, av[k], bv[k]);
      wait_rdy(lat);
      checks++;
      if (lat != 32 || bus.data_result !== er || bus.data_exception !== ee) begin
        errors++;
        $display("FAIL div_%0d: %h/%h lat %0d got %h/%b want 32 %h/%b",
                 k, av[k], bv[k], lat, bus.data_result,
                 bus.data_exception, er, ee);
      end
    end
`ifdef MULTDIV_DIV_EN
    checks++;
    if (bus.data_result !== 32'd14) begin
      errors++;
      $display("FAIL div_100_7: got %h want e", bus.data_result);
    end
`endif
  endtask

  task automatic test_both_high();
    int lat;
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    wait_rdy(lat);
    checks++;
    if (lat != 32 || bus.data_result !== 32'd18 || bus.data_exception !== 1'b0) begin
      errors++;
      $display("FAIL both_high: lat %0d got %h/%b want 32 12/0",
               lat, bus.data_result, bus.data_exception);
    end
  endtask

  task automatic test_restart();
    int          lat;
    int          seen;
    logic [31:0] er;
    logic        ee;
    start_op(1'b1, 1'b0, 32'd2, 32'd3);
    wait_rdy(lat);
    start_op(1'b1, 1'b0, 32'd9, 32'd9);
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) seen++;
    end
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    checks++;
    if (bus.data_result !== 32'd6) begin
      errors++;
      $display("FAIL restart_hold: got %h want 6", bus.data_result);
    end
    wait_rdy(lat);
    ref_op(1'b0, 32'd100, 32'd7, er, ee);
    checks++;
    if (seen != 0 || lat != 32 || bus.data_result !== er ||
        bus.data_exception !== ee) begin
      errors++;
      $display("FAIL restart: early rdy %0d lat %0d got %h/%b want 0 32 %h/%b",
               seen, lat, bus.data_result, bus.data_exception, er, ee);
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    bit          m;
    logic [31:0] a, b, er;
    logic        ee;
    for (int k = 0; k < 16; k++) begin
      m = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      ref_op(m, a, b, er, ee);
      start_op(m, !m, a, b);
      wait_rdy(lat);
      checks++;
      if (lat != 32 || bus.data_result !== er || bus.data_exception !== ee) begin
        errors++;
        $display("FAIL b2b_%0d %s %h,%h: lat %0d got %h/%b want 32 %h/%b",
                 k, m ? "mul" : "div", a, b, lat, bus.data_result,
                 bus.data_exception, er, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_mult_overflow();
    test_div();
    test_both_high();
    test_restart();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
